// File: rtl/reg_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_wr_arbiter_pkg
// Shared types and helpers for the register-bank write-port arbiter.
//   arb_state_e : arbiter state (idle search / burst lock)
//   idx_w()     : width of a requester index for a given requester count
// ---------------------------------------------------------------------------
package reg_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Requester index width; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        if (n < 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage : reg_wr_arbiter_pkg

// File: rtl/reg_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// reg_wr_arbiter_rr_pick
// Combinational rotate-priority encoder. Starting at ptr_i and wrapping
// modulo NREQ, reports the first requester whose valid bit is set.
// Ports:
//   valid_i [NREQ] : request vector
//   ptr_i   [IW]   : highest-priority index (always < NREQ)
//   grant_o [IW]   : index of the winning requester (0 when none)
//   any_o          : at least one requester is valid
// ---------------------------------------------------------------------------
module reg_wr_arbiter_rr_pick
    import reg_wr_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [IW-1:0]   grant_o,
    output logic            any_o
);

    // One spare bit so ptr + offset cannot overflow before the wrap.
    localparam int SW = IW + 1;

    logic [SW-1:0] cand_s;
    logic [IW-1:0] grant_s;
    logic          any_s;

    // Walk the search order ptr, ptr+1, ... and keep the first valid hit.
    always_comb begin
        cand_s  = '0;
        grant_s = '0;
        any_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = {1'b0, ptr_i} + SW'(k);
            if (cand_s >= SW'(NREQ)) begin
                cand_s = cand_s - SW'(NREQ);
            end else begin
                cand_s = cand_s;
            end
            if (!any_s && valid_i[cand_s[IW-1:0]]) begin
                any_s   = 1'b1;
                grant_s = cand_s[IW-1:0];
            end else begin
                any_s   = any_s;
            end
        end
    end

    assign grant_o = grant_s;
    assign any_o   = any_s;

endmodule : reg_wr_arbiter_rr_pick

// File: rtl/reg_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_wr_arbiter
// Round-robin arbiter sharing the single write port of a register bank
// between NREQ requesters, with burst locking. Write outputs are registered
// and feed the bank's per-register clock enable / data directly.
// Ports:
//   C_i, R_i           : clock (rising edge), synchronous active-high reset
//   req_valid_i [NREQ] : per-requester beat valid
//   req_last_i  [NREQ] : beat is the final one of its burst
//   req_addr_i  [NREQ*AW], req_data_i [NREQ*DW] : packed, requester i at i*W
//   req_ready_o [NREQ] : combinational one-hot/zero accept
//   stall_i            : freezes arbitration and acceptance
//   wr_en_o, wr_addr_o, wr_data_o, wr_src_o : registered bank write beat
//   locked_o           : registered, high while a burst owns the port
// ---------------------------------------------------------------------------
module reg_wr_arbiter
    import reg_wr_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit ZERO_WR = 1'b0
) (
    input  logic                  C_i,
    input  logic                  R_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ-1:0]       req_last_i,
    input  logic [NREQ*AW-1:0]    req_addr_i,
    input  logic [NREQ*DW-1:0]    req_data_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic                  stall_i,
    output logic                  wr_en_o,
    output logic [AW-1:0]         wr_addr_o,
    output logic [DW-1:0]         wr_data_o,
    output logic [idx_w(NREQ)-1:0] wr_src_o,
    output logic                  locked_o
);

    localparam int IW = idx_w(NREQ);

    // Sequential state
    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [IW-1:0] wr_src_q, wr_src_d;
    logic          locked_q, locked_d;

    // Combinational datapath
    logic [IW-1:0]   grant_s;
    logic            any_s;
    logic [NREQ-1:0] ready_s;
    logic            accept_s;
    logic [IW-1:0]   sel_s;
    logic [IW-1:0]   next_ptr_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            sel_last_s;

    reg_wr_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .any_o   (any_s)
    );

    // Ready generation: search winner when idle, owner only when locked.
    // Reset and stall both force every ready bit low.
    always_comb begin
        ready_s = '0;
        if (R_i || stall_i) begin
            ready_s = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_s) begin
                        ready_s[grant_s] = 1'b1;
                    end else begin
                        ready_s = '0;
                    end
                end
                ST_LOCK: begin
                    ready_s[owner_q] = req_valid_i[owner_q];
                end
                default: begin
                    ready_s = '0;
                end
            endcase
        end
    end

    assign req_ready_o = ready_s;
    assign accept_s    = |(req_valid_i & ready_s);
    assign sel_s       = (state_q == ST_LOCK) ? owner_q : grant_s;

    // Fetch the address/data/last of the requester currently being served.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        sel_last_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_s == IW'(i)) begin
                sel_addr_s = req_addr_i[i*AW +: AW];
                sel_data_s = req_data_i[i*DW +: DW];
                sel_last_s = req_last_i[i];
            end else begin
                sel_last_s = sel_last_s;
            end
        end
    end

    // Pointer successor of the served requester, wrapping at NREQ-1.
    always_comb begin
        if (sel_s == IW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = sel_s + IW'(1);
        end
    end

    // FSM next state: a non-last beat in IDLE locks, a last beat unlocks.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (sel_last_s) begin
                        ptr_d = next_ptr_s;
                    end else begin
                        state_d = ST_LOCK;
                        owner_d = grant_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (accept_s && sel_last_s) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr_s;
                end else begin
                    state_d = ST_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
                owner_d = '0;
            end
        endcase
    end

    // Output register next values: load the beat on accept, else drop the
    // strobe and hold the last address/data/source for the bank.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        locked_d  = (state_d == ST_LOCK);
        if (accept_s) begin
            // Address 0 is a hard-wired zero register unless ZERO_WR is set.
            wr_en_d   = ZERO_WR || (sel_addr_s != AW'(0));
            wr_addr_d = sel_addr_s;
            wr_data_d = sel_data_s;
            wr_src_d  = sel_s;
        end else begin
            wr_en_d   = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge C_i) begin
        if (R_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
            locked_q  <= locked_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign wr_src_o  = wr_src_q;
    assign locked_o  = locked_q;

endmodule : reg_wr_arbiter

// File: tb/tb_reg_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_wr_arbiter
// Directed bench for reg_wr_arbiter (NREQ=4, DW=32, AW=5). A second instance
// with ZERO_WR=1 shares the stimulus to show address-0 writes are enabled.
// ---------------------------------------------------------------------------
module tb_reg_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic              clk;
    logic              rst;
    logic              stall;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    logic [NREQ-1:0]   rdy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [1:0]        wr_src;
    logic              locked;

    logic [NREQ-1:0]   rdy_z;
    logic              wr_en_z;
    logic [AW-1:0]     wr_addr_z;
    logic [DW-1:0]     wr_data_z;
    logic [1:0]        wr_src_z;
    logic              locked_z;

    logic          tv [NREQ];
    logic          tl [NREQ];
    logic [AW-1:0] ta [NREQ];
    logic [DW-1:0] td [NREQ];

    int n_checks = 0;
    int n_errors = 0;

    reg_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .ZERO_WR(1'b0)) dut (
        .C_i(clk), .R_i(rst), .req_valid_i(req_valid), .req_last_i(req_last),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_ready_o(rdy),
        .stall_i(stall), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .wr_data_o(wr_data), .wr_src_o(wr_src), .locked_o(locked)
    );

    reg_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .ZERO_WR(1'b1)) dut_z (
        .C_i(clk), .R_i(rst), .req_valid_i(req_valid), .req_last_i(req_last),
        .req_addr_i(req_addr), .req_data_i(req_data), .req_ready_o(rdy_z),
        .stall_i(stall), .wr_en_o(wr_en_z), .wr_addr_o(wr_addr_z),
        .wr_data_o(wr_data_z), .wr_src_o(wr_src_z), .locked_o(locked_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack the per-requester stimulus arrays onto the DUT buses.
    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_addr  = '0;
        req_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_valid[k]           = tv[k];
            req_last[k]            = tl[k];
            req_addr[k*AW +: AW]   = ta[k];
            req_data[k*DW +: DW]   = td[k];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        tv[i] = v;
        tl[i] = l;
        ta[i] = a;
        td[i] = d;
    endtask

    task automatic clr_all();
        for (int k = 0; k < NREQ; k++) begin
            set_req(k, 1'b0, 1'b1, 5'd0, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_rdy;
        int g;

        // ---------------- reset, with all requesters valid ----------------
        rst   = 1'b1;
        stall = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            set_req(k, 1'b1, 1'b1, 5'(k + 1), 32'hA0 + 32'(k));
        end
        #1;
        chk("rdy_in_reset", 64'(rdy), 64'd0);
        tick();
        tick();
        chk("rst_wr_en",   64'(wr_en),   64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_src",  64'(wr_src),  64'd0);
        chk("rst_locked",  64'(locked),  64'd0);

        // ---------------- round robin 0,1,2,3,0 --------------------------
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            g = n % 4;
            exp_rdy = 4'b0001 << g;
            #1;
            chk("rr_ready", 64'(rdy), 64'(exp_rdy));
            tick();
            chk("rr_wr_en",   64'(wr_en),   64'd1);
            chk("rr_wr_src",  64'(wr_src),  64'(g));
            chk("rr_wr_addr", 64'(wr_addr), 64'(g + 1));
            chk("rr_wr_data", 64'(wr_data), 64'(32'hA0 + 32'(g)));
        end
        // ptr is now 1

        // ---------------- single from requester 1, ptr -> 2 ---------------
        clr_all();
        set_req(1, 1'b1, 1'b1, 5'd9, 32'h11);
        #1;
        chk("s1_ready", 64'(rdy), 64'b0010);
        tick();
        chk("s1_src",    64'(wr_src),  64'd1);
        chk("s1_addr",   64'(wr_addr), 64'd9);
        chk("s1_locked", 64'(locked),  64'd0);

        // ---------------- burst from requester 2 --------------------------
        set_req(0, 1'b1, 1'b1, 5'd1, 32'hA0);
        set_req(1, 1'b1, 1'b1, 5'd2, 32'hA1);
        set_req(2, 1'b1, 1'b0, 5'd5, 32'h205);
        #1;
        chk("b1_ready", 64'(rdy), 64'b0100);
        tick();
        chk("b1_addr",   64'(wr_addr), 64'd5);
        chk("b1_data",   64'(wr_data), 64'h205);
        chk("b1_src",    64'(wr_src),  64'd2);
        chk("b1_en",     64'(wr_en),   64'd1);
        chk("b1_locked", 64'(locked),  64'd1);

        // owner drops valid for two cycles: nobody else is granted
        tv[2] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            #1;
            chk("gap_ready", 64'(rdy), 64'b0000);
            tick();
            chk("gap_en",     64'(wr_en),   64'd0);
            chk("gap_addr",   64'(wr_addr), 64'd5);
            chk("gap_locked", 64'(locked),  64'd1);
        end

        set_req(2, 1'b1, 1'b0, 5'd6, 32'h206);
        #1;
        chk("b2_ready", 64'(rdy), 64'b0100);
        tick();
        chk("b2_addr",   64'(wr_addr), 64'd6);
        chk("b2_en",     64'(wr_en),   64'd1);
        chk("b2_locked", 64'(locked),  64'd1);

        set_req(2, 1'b1, 1'b1, 5'd7, 32'h207);
        #1;
        chk("b3_ready", 64'(rdy), 64'b0100);
        tick();
        chk("b3_addr",   64'(wr_addr), 64'd7);
        chk("b3_src",    64'(wr_src),  64'd2);
        chk("b3_locked", 64'(locked),  64'd0);

        // ptr = 3, requester 3 idle -> search wraps to requester 0
        tv[2] = 1'b0;
        #1;
        chk("post_ready", 64'(rdy), 64'b0001);
        tick();
        chk("post_src",  64'(wr_src),  64'd0);
        chk("post_data", 64'(wr_data), 64'hA0);
        // ptr is now 1

        // ---------------- stall for three cycles --------------------------
        stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stall_ready", 64'(rdy), 64'b0000);
            tick();
            chk("stall_en",   64'(wr_en),   64'd0);
            chk("stall_addr", 64'(wr_addr), 64'd1);
            chk("stall_src",  64'(wr_src),  64'd0);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", 64'(rdy), 64'b0010);
        tick();
        chk("unstall_src",  64'(wr_src),  64'd1);
        chk("unstall_addr", 64'(wr_addr), 64'd2);
        chk("unstall_en",   64'(wr_en),   64'd1);
        // ptr is now 2

        // ---------------- write to address 0 ------------------------------
        clr_all();
        set_req(2, 1'b1, 1'b1, 5'd0, 32'h5A);
        #1;
        chk("z_ready", 64'(rdy), 64'b0100);
        tick();
        chk("z_en_suppressed", 64'(wr_en),   64'd0);
        chk("z_en_allowed",    64'(wr_en_z), 64'd1);
        chk("z_addr",          64'(wr_addr), 64'd0);
        chk("z_src",           64'(wr_src),  64'd2);
        chk("z_data",          64'(wr_data), 64'h5A);

        // pointer advanced past 2 even though the write was suppressed
        set_req(3, 1'b1, 1'b1, 5'd3, 32'h33);
        #1;
        chk("z_next_ready", 64'(rdy), 64'b1000);
        tick();
        chk("z_next_src", 64'(wr_src), 64'd3);
        chk("z_next_en",  64'(wr_en),  64'd1);
        // ptr wrapped to 0

        // ---------------- reset mid-burst together with stall ------------
        clr_all();
        set_req(1, 1'b1, 1'b0, 5'd4, 32'h44);
        #1;
        chk("rb_ready", 64'(rdy), 64'b0010);
        tick();
        chk("rb_locked", 64'(locked), 64'd1);
        chk("rb_src",    64'(wr_src), 64'd1);

        stall = 1'b1;
        rst   = 1'b1;
        #1;
        chk("rb_rst_ready", 64'(rdy), 64'b0000);
        tick();
        chk("rb_rst_locked", 64'(locked),  64'd0);
        chk("rb_rst_en",     64'(wr_en),   64'd0);
        chk("rb_rst_addr",   64'(wr_addr), 64'd0);
        chk("rb_rst_data",   64'(wr_data), 64'd0);
        chk("rb_rst_src",    64'(wr_src),  64'd0);

        // back to IDLE with ptr=0: requester 0 wins, burst owner 1 forgotten
        rst   = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            set_req(k, 1'b1, 1'b1, 5'(k + 1), 32'hC0 + 32'(k));
        end
        #1;
        chk("after_rst_ready", 64'(rdy), 64'b0001);
        tick();
        chk("after_rst_src",    64'(wr_src), 64'd0);
        chk("after_rst_locked", 64'(locked), 64'd0);
        chk("after_rst_data",   64'(wr_data), 64'hC0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_wr_arbiter

// File: doc/reg_wr_arbiter.md
# reg_wr_arbiter

Round-robin arbiter that shares the single write port of a register bank between NREQ requesters. The bank is built from synchronous-reset, clock-enabled N-bit registers. Each requester offers address/data beats on a valid/ready handshake and may lock the port for a multi-beat burst. Outputs are registered and drive the bank's per-register clock enable and data directly. The block sits between the execute/load/CSR write-back sources and the register bank.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 32: data width
- AW, 5: write address width
- ZERO_WR, 0: when 0, writes to address 0 are accepted but suppressed (wr_en stays 0)

- C  in  1  clock, rising edge
- R  in  1  reset, synchronous, active-high
- req_valid  in  NREQ  per-requester beat valid
- req_last  in  NREQ  beat is final of burst; single beat = last=1
- req_addr  in  NREQ*AW  packed, requester i at [i*AW +: AW]
- req_data  in  NREQ*DW  packed, requester i at [i*DW +: DW]
- req_ready  out  NREQ  one-hot or zero; beat i accepted when valid&ready
- stall  in  1  freezes arbitration and acceptance
- wr_en  out  1  registered write strobe to bank
- wr_addr  out  AW  registered write address
- wr_data  out  DW  registered write data
- wr_src  out  $clog2(NREQ)  registered index of requester that produced the current write
- locked  out  1  registered; burst ownership held

## Operation
- State machine: IDLE, LOCK.
- Pointer ptr holds the highest-priority index. Search order is ptr, ptr+1, …, wrapping modulo NREQ.
- **IDLE, stall=0:** grant g is the first i in search order with req_valid[i]=1. req_ready[g]=1 combinationally; all other ready bits are 0.
  - Accept with last=1: stay IDLE, ptr←(g+1) mod NREQ.
  - Accept with last=0: go to LOCK, owner←g, ptr unchanged.
- **LOCK, stall=0:**
  - req_ready[owner]=req_valid[owner]; all other ready bits are 0.
  - Accept with last=1: go to IDLE, ptr←(owner+1) mod NREQ.
  - Owner valid low: hold LOCK. No timeout.
- **stall=1:** req_ready=0. State, ptr and owner are held. Output registers load wr_en=0, and wr_addr/wr_data hold.
- **Output registers** load on every accepted beat:
  - wr_en←1, or 0 if ZERO_WR=0 and addr==0
  - wr_addr, wr_data, wr_src←beat
- **Cycle with no accept:** wr_en←0; wr_addr, wr_data, wr_src hold.
- locked=1 exactly while state is LOCK.

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - wr_en=0, wr_addr=0, wr_data=0, wr_src=0, locked=0
  - req_ready=0 during the cycle R is sampled high
- Reset mid-burst abandons the burst. A partial write already issued is not undone.
- Latency: a beat accepted at edge n appears on wr_* after edge n and is written to the bank at edge n+1.
- Throughput: one beat per cycle, including back-to-back beats from different requesters.
- req_ready depends combinationally on req_valid, state, ptr and stall. It never depends on wr_*.
- Requesters must hold valid/addr/data/last stable until accepted.
- req_valid may drop without acceptance. The arbiter must not latch unaccepted beats.
- Simultaneous events:
  - stall and R both high: R wins.
  - Last beat of a burst: the next requester may be granted on the following cycle, not the same cycle.
- Wrap-around: ptr=NREQ-1 plus an accept advances ptr to 0.

## Structure
- Shared package holds:
  - the state enum (IDLE, LOCK)
  - the index width function, clog2 of NREQ
- Sub-module rr_pick:
  - combinational rotate-priority encoder
  - inputs: valid vector, ptr
  - outputs: grant index, any
- All sequential state lives in the top module:
  - state, ptr, owner, output registers
- Output registers are clock-enabled, synchronous-reset registers, CE = accept|stall-clear of wr_en.

## Test plan
- Reset, then all four valid, single beats, ptr=0 → accepts in order 0,1,2,3,0. wr_src follows one cycle later. wr_en=1 every cycle.
- Requester 2 bursts 3 beats (addr 5,6,7; last on beat 3) while 0 and 1 are valid → locked=1 for beats 1–3. Only ready[2] asserts. Grant 3 is next if valid, else 0.
- Burst owner drops valid for 2 cycles mid-burst → no other grant. wr_en=0 for those cycles, burst resumes.
- stall=1 for 3 cycles with requests pending → req_ready=0, wr_en=0, ptr unchanged. After release, the same requester wins.
- Write to addr 0 with ZERO_WR=0 → handshake completes and ptr advances, but wr_en=0. With ZERO_WR=1, wr_en=1.
- R asserted mid-burst with stall=1 → next cycle state=IDLE, locked=0, ptr=0, all wr_* =0.
